// File: rtl/mem_port_arbiter_if.sv
// Request/grant/rvalid bundle for the fetch, data and memory sides of mem_port_arbiter.
// The slave modport is the arbiter's view; master is the view of whatever drives it.
interface mem_port_arbiter_if;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;

  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;

  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
  );

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one req/gnt/rvalid memory port between instruction fetch and data access.
// A source-tag FIFO steers in-order responses back to the requester that issued them.
module mem_port_arbiter #(
  parameter int MaxOutstanding = 2,
  parameter bit DataFirst      = 1'b1
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  mem_port_arbiter_if.slave       bus,
  output logic [2:0]              outstanding_o,
  output logic                    protocol_err_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_I = 2'd1,
    LOCK_D = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        last_data_q, last_data_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic        proto_err_q, proto_err_d;
  logic        tag_mem_q [4];

  logic        full, empty;
  logic        owner_data, owner_req;
  logic        mem_req, gnt, push, pop, head_data;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(MaxOutstanding - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  assign full      = (count_q == 3'(MaxOutstanding));
  assign empty     = (count_q == 3'd0);
  assign head_data = tag_mem_q[rd_ptr_q];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    owner_data = 1'b0;
    owner_req  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!full) begin
          // On a tie the side not granted most recently wins.
          if (bus.data_req_i && (!bus.instr_req_i || !last_data_q)) begin
            owner_data = 1'b1;
            owner_req  = 1'b1;
          end else if (bus.instr_req_i) begin
            owner_req  = 1'b1;
          end
        end
      end
      LOCK_I: owner_req = bus.instr_req_i;
      LOCK_D: begin
        owner_data = 1'b1;
        owner_req  = bus.data_req_i;
      end
      default: ;
    endcase

    mem_req = owner_req && !full;
    gnt     = mem_req && bus.mem_gnt_i;
    push    = gnt;
    pop     = bus.mem_rvalid_i && !empty;

    // A locked request blocked by a full FIFO keeps its lock until it is granted.
    if (mem_req && !gnt)        state_d = owner_data ? LOCK_D : LOCK_I;
    else if (gnt || !owner_req) state_d = IDLE;

    last_data_d = push ? owner_data : last_data_q;
    wr_ptr_d    = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d     = count_q + {2'b00, push} - {2'b00, pop};
    proto_err_d = proto_err_q || (bus.mem_rvalid_i && empty);
  end

  assign bus.mem_req_o      = mem_req;
  assign bus.mem_we_o       = owner_data ? bus.data_we_i    : 1'b0;
  assign bus.mem_be_o       = owner_data ? bus.data_be_i    : 4'hF;
  assign bus.mem_addr_o     = owner_data ? bus.data_addr_i  : bus.instr_addr_i;
  assign bus.mem_wdata_o    = owner_data ? bus.data_wdata_i : 32'h0;

  assign bus.instr_gnt_o    = gnt && !owner_data;
  assign bus.data_gnt_o     = gnt &&  owner_data;
  assign bus.instr_rvalid_o = pop && !head_data;
  assign bus.data_rvalid_o  = pop &&  head_data;
  assign bus.instr_rdata_o  = bus.mem_rdata_i;
  assign bus.data_rdata_o   = bus.mem_rdata_i;
  assign bus.instr_err_o    = bus.mem_err_i;
  assign bus.data_err_o     = bus.mem_err_i;

  assign outstanding_o      = count_q;
  assign protocol_err_o     = proto_err_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      last_data_q <= ~DataFirst;
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      count_q     <= 3'd0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_data_q <= last_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      proto_err_q <= proto_err_d;
    end
  end

  // NOTE: tag storage is not reset; an entry is only read after it was written, and the count gates reads.
  always_ff @(posedge CLK) begin
    if (push) tag_mem_q[wr_ptr_q] <= owner_data;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MaxOutstanding=2, DataFirst=1) with hand-computed expectations.
module tb_mem_port_arbiter;

  logic       CLK;
  logic       RST_N;
  logic [2:0] outstanding;
  logic       protocol_err;
  int         n_checks = 0;
  int         n_errors = 0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.MaxOutstanding(2), .DataFirst(1'b1)) dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .bus            (bus),
    .outstanding_o  (outstanding),
    .protocol_err_o (protocol_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; registered outputs are then sampled 1 ns later.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    bus.instr_req_i  = 1'b0;
    bus.instr_addr_i = 32'h0;
    bus.data_req_i   = 1'b0;
    bus.data_we_i    = 1'b0;
    bus.data_be_i    = 4'h0;
    bus.data_addr_i  = 32'h0;
    bus.data_wdata_i = 32'h0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = 32'h0;
    bus.mem_err_i    = 1'b0;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    RST_N = 1'b0;
    step();
    step();
    RST_N = 1'b1;

    // Reset state
    settle();
    check("rst_outstanding", 32'(outstanding), 32'd0);
    check("rst_proto_err",   32'(protocol_err), 32'd0);
    check("rst_mem_req",     32'(bus.mem_req_o), 32'd0);
    check("rst_gnts",        {30'd0, bus.instr_gnt_o, bus.data_gnt_o}, 32'd0);
    check("rst_rvalids",     {30'd0, bus.instr_rvalid_o, bus.data_rvalid_o}, 32'd0);

    // Fetch only
    bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h80; bus.mem_gnt_i = 1'b1;
    settle();
    check("f_instr_gnt", 32'(bus.instr_gnt_o), 32'd1);
    check("f_data_gnt",  32'(bus.data_gnt_o), 32'd0);
    check("f_mem_addr",  bus.mem_addr_o, 32'h80);
    check("f_mem_ctl",   {23'd0, bus.mem_we_o, bus.mem_be_o, 4'd0}, {23'd0, 1'b0, 4'hF, 4'd0});
    check("f_mem_wdata", bus.mem_wdata_o, 32'h0);
    step();
    bus.instr_req_i = 1'b0; bus.mem_gnt_i = 1'b0;
    check("f_out1", 32'(outstanding), 32'd1);
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h0000_0013;
    settle();
    check("f_instr_rvalid", 32'(bus.instr_rvalid_o), 32'd1);
    check("f_instr_rdata",  bus.instr_rdata_o, 32'h0000_0013);
    check("f_data_rvalid",  32'(bus.data_rvalid_o), 32'd0);
    step();
    bus.mem_rvalid_i = 1'b0;
    check("f_out0", 32'(outstanding), 32'd0);

    // Tie after reset: data first, then instr, then data wins again
    do_reset();
    bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h84;
    bus.data_req_i = 1'b1; bus.data_we_i = 1'b1; bus.data_be_i = 4'h3;
    bus.data_addr_i = 32'h2000; bus.data_wdata_i = 32'hDEAD_BEEF;
    bus.mem_gnt_i = 1'b1;
    settle();
    check("t1_data_gnt",  32'(bus.data_gnt_o), 32'd1);
    check("t1_instr_gnt", 32'(bus.instr_gnt_o), 32'd0);
    check("t1_mem_we",    32'(bus.mem_we_o), 32'd1);
    check("t1_mem_be",    32'(bus.mem_be_o), 32'h3);
    check("t1_mem_addr",  bus.mem_addr_o, 32'h2000);
    check("t1_mem_wdata", bus.mem_wdata_o, 32'hDEAD_BEEF);
    step();
    bus.data_req_i = 1'b0;
    settle();
    check("t2_instr_gnt", 32'(bus.instr_gnt_o), 32'd1);
    check("t2_mem_addr",  bus.mem_addr_o, 32'h84);
    check("t2_mem_we",    32'(bus.mem_we_o), 32'd0);
    step();
    bus.instr_req_i = 1'b0; bus.mem_gnt_i = 1'b0;
    check("t_out2", 32'(outstanding), 32'd2);
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h11;
    settle();
    check("t_resp1_data",  {30'd0, bus.instr_rvalid_o, bus.data_rvalid_o}, 32'b01);
    step();
    bus.mem_rdata_i = 32'h22;
    settle();
    check("t_resp2_instr", {30'd0, bus.instr_rvalid_o, bus.data_rvalid_o}, 32'b10);
    step();
    bus.mem_rvalid_i = 1'b0;
    check("t_out0", 32'(outstanding), 32'd0);
    // Second tie: instr was granted last, so data wins
    bus.instr_req_i = 1'b1; bus.data_req_i = 1'b1; bus.mem_gnt_i = 1'b1;
    settle();
    check("t3_data_gnt", {30'd0, bus.instr_gnt_o, bus.data_gnt_o}, 32'b01);
    step();
    bus.data_req_i = 1'b0;
    settle();
    check("t4_instr_gnt", {30'd0, bus.instr_gnt_o, bus.data_gnt_o}, 32'b10);
    step();
    bus.instr_req_i = 1'b0; bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1;
    step();
    step();
    bus.mem_rvalid_i = 1'b0;
    check("t_drain", 32'(outstanding), 32'd0);

    // One data-only transaction so that data is the last granted side
    bus.data_req_i = 1'b1; bus.data_we_i = 1'b0; bus.data_addr_i = 32'h1800; bus.mem_gnt_i = 1'b1;
    step();
    bus.data_req_i = 1'b0; bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1;
    settle();
    check("pre_data_rvalid", 32'(bus.data_rvalid_o), 32'd1);
    step();
    bus.mem_rvalid_i = 1'b0;

    // Lock: data holds the port through 3 ungranted cycles although instr would win a tie
    bus.data_req_i = 1'b1; bus.data_addr_i = 32'h1000;
    settle();
    check("l0_mem_req",  32'(bus.mem_req_o), 32'd1);
    check("l0_mem_addr", bus.mem_addr_o, 32'h1000);
    step();
    bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h90;
    for (int c = 1; c < 3; c++) begin
      settle();
      check("l_mem_addr", bus.mem_addr_o, 32'h1000);
      check("l_gnts", {30'd0, bus.instr_gnt_o, bus.data_gnt_o}, 32'b00);
      step();
    end
    bus.mem_gnt_i = 1'b1;
    settle();
    check("l3_data_gnt", {30'd0, bus.instr_gnt_o, bus.data_gnt_o}, 32'b01);
    check("l3_mem_addr", bus.mem_addr_o, 32'h1000);
    step();
    bus.data_req_i = 1'b0;
    settle();
    check("l4_instr_gnt", {30'd0, bus.instr_gnt_o, bus.data_gnt_o}, 32'b10);
    check("l4_mem_addr",  bus.mem_addr_o, 32'h90);
    step();
    bus.instr_req_i = 1'b0; bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1;
    settle();
    check("l_resp1", {30'd0, bus.instr_rvalid_o, bus.data_rvalid_o}, 32'b01);
    step();
    settle();
    check("l_resp2", {30'd0, bus.instr_rvalid_o, bus.data_rvalid_o}, 32'b10);
    step();
    bus.mem_rvalid_i = 1'b0;

    // Backpressure: two fetch grants fill the FIFO
    bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'hA0; bus.mem_gnt_i = 1'b1;
    step();
    bus.instr_addr_i = 32'hA4;
    step();
    bus.instr_req_i = 1'b0;
    bus.data_req_i = 1'b1; bus.data_we_i = 1'b1; bus.data_addr_i = 32'h3000;
    settle();
    check("bp_out2",    32'(outstanding), 32'd2);
    check("bp_mem_req", 32'(bus.mem_req_o), 32'd0);
    check("bp_gnt",     32'(bus.data_gnt_o), 32'd0);
    step();
    check("bp_mem_req2", 32'(bus.mem_req_o), 32'd0);
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h55;
    settle();
    check("bp_resp1",      {30'd0, bus.instr_rvalid_o, bus.data_rvalid_o}, 32'b10);
    check("bp_no_through", 32'(bus.mem_req_o), 32'd0);
    step();
    // Space freed: request re-presented, granted, and a pop lands in the same cycle
    settle();
    check("bp_mem_req3",  32'(bus.mem_req_o), 32'd1);
    check("bp_data_gnt",  32'(bus.data_gnt_o), 32'd1);
    check("bp_resp2",     {30'd0, bus.instr_rvalid_o, bus.data_rvalid_o}, 32'b10);
    step();
    bus.data_req_i = 1'b0; bus.mem_gnt_i = 1'b0;
    check("bp_pushpop_out", 32'(outstanding), 32'd1);
    settle();
    check("bp_resp3", {30'd0, bus.instr_rvalid_o, bus.data_rvalid_o}, 32'b01);
    step();
    bus.mem_rvalid_i = 1'b0;
    check("bp_out0", 32'(outstanding), 32'd0);

    // Spurious response with empty FIFO
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h99;
    settle();
    check("sp_rvalids", {30'd0, bus.instr_rvalid_o, bus.data_rvalid_o}, 32'b00);
    check("sp_err_pre", 32'(protocol_err), 32'd0);
    step();
    bus.mem_rvalid_i = 1'b0;
    check("sp_err_set", 32'(protocol_err), 32'd1);
    step();
    step();
    check("sp_err_sticky", 32'(protocol_err), 32'd1);
    check("sp_out", 32'(outstanding), 32'd0);

    // Reset mid-operation
    do_reset();
    check("r_err_clr", 32'(protocol_err), 32'd0);
    bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'hB0; bus.mem_gnt_i = 1'b1;
    step();
    bus.instr_req_i = 1'b0; bus.mem_gnt_i = 1'b0;
    check("r_out1", 32'(outstanding), 32'd1);
    do_reset();
    check("r_out0", 32'(outstanding), 32'd0);
    bus.mem_rvalid_i = 1'b1;
    settle();
    check("r_late_rvalid", {30'd0, bus.instr_rvalid_o, bus.data_rvalid_o}, 32'b00);
    step();
    bus.mem_rvalid_i = 1'b0;
    check("r_late_err", 32'(protocol_err), 32'd1);
    bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'hC0; bus.mem_gnt_i = 1'b1;
    settle();
    check("r_new_gnt", 32'(bus.instr_gnt_o), 32'd1);
    step();
    bus.instr_req_i = 1'b0; bus.mem_gnt_i = 1'b0;
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h77;
    settle();
    check("r_new_rvalid", {30'd0, bus.instr_rvalid_o, bus.data_rvalid_o}, 32'b10);
    check("r_new_rdata",  bus.instr_rdata_o, 32'h77);
    step();
    bus.mem_rvalid_i = 1'b0;
    check("r_new_out0", 32'(outstanding), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one external memory port between the pipeline's instruction-fetch and data (load/store) interfaces. Both sides and the memory side use the req/gnt/rvalid protocol.
- Sits between cpu_pipeline and a unified single-port memory model. Lets the core run on testbenches and SoCs that provide only one bus master port.
- Tracks in-order outstanding transactions with a source-tag FIFO. Routes each response back to the requester that issued it.

Parameters:
- MaxOutstanding, 2, maximum granted-but-unanswered transactions; legal range 1..4.
- DataFirst, 1, requester preferred at reset and on ties when the round-robin pointer is reset: 1 = data, 0 = instr.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  synchronous active-low reset.
- instr_req_i  input  1  fetch request; held until instr_gnt_o.
- instr_addr_i  input  32  fetch address.
- instr_gnt_o  output  1  fetch request accepted this cycle.
- instr_rvalid_o  output  1  fetch response valid.
- instr_rdata_o  output  32  fetch response data.
- instr_err_o  output  1  fetch response error.
- data_req_i  input  1  data request; held until data_gnt_o.
- data_we_i  input  1  data write enable.
- data_be_i  input  4  data byte enables.
- data_addr_i  input  32  data address.
- data_wdata_i  input  32  data write data.
- data_gnt_o  output  1  data request accepted.
- data_rvalid_o  output  1  data response valid.
- data_rdata_o  output  32  data response data.
- data_err_o  output  1  data response error.
- mem_req_o  output  1  memory request.
- mem_we_o  output  1  memory write enable; 0 for fetches.
- mem_be_o  output  4  memory byte enables; 4'hF for fetches.
- mem_addr_o  output  32  memory address.
- mem_wdata_o  output  32  memory write data; 0 for fetches.
- mem_gnt_i  input  1  memory grant.
- mem_rvalid_i  input  1  memory response valid.
- mem_rdata_i  input  32  memory response data.
- mem_err_i  input  1  memory response error.
- outstanding_o  output  3  current count of unanswered transactions.
- protocol_err_o  output  1  sticky flag: response received while no transaction was outstanding.

Behaviour:
- **Reset** (RST_N low at a rising edge):
  - FIFO empties and outstanding_o = 0.
  - protocol_err_o = 0 and FSM = IDLE.
  - Round-robin pointer set so the DataFirst side wins the next tie.
  - All gnt/rvalid outputs evaluate to 0 while the FIFO is empty and no request is present.
  - Transactions in flight at reset are forgotten; their late responses are handled under the "empty FIFO" rule.
- **FSM states:**
  - IDLE: no locked owner.
  - LOCK_I: instr owns mem_req_o, not yet granted.
  - LOCK_D: data owns mem_req_o, not yet granted.
- **Selection in IDLE**, when the FIFO is not full:
  - If only one requester is asserting, it is selected.
  - If both are asserting, the one not granted most recently is selected (round-robin).
- **mem_req_o** = selected or locked request AND FIFO not full.
  - mem_* address/control fields mux from the owner combinationally.
  - gnt_o to the owner = mem_gnt_i AND mem_req_o. The other gnt_o stays 0.
- **Grant in the same cycle as request:**
  - The FSM stays IDLE.
  - The owner's tag is pushed to the FIFO.
  - The round-robin pointer is updated to mark the owner as last granted.
- **Request without grant:**
  - The FSM moves to LOCK_x and holds the owner until mem_gnt_i. A competing request cannot preempt it; this keeps address/control stable.
  - On the grant, the tag is pushed, the pointer is updated and the FSM returns to IDLE.
- **FIFO full** (outstanding_o == MaxOutstanding):
  - mem_req_o is forced to 0 and no gnt is issued.
  - A lock state persists and re-presents the request once space frees.
  - A pop in a cycle with a full FIFO frees space only from the next cycle; there is no same-cycle push-through.
- **Responses:**
  - mem_rvalid_i pops the head tag and drives rvalid_o of that tag's owner in the same cycle.
  - rdata/err pass through to both sides unconditionally; only rvalid is qualified.
- **Push and pop in the same cycle** (FIFO not full): outstanding_o is unchanged and the pointers both advance.
- **mem_rvalid_i with an empty FIFO:**
  - The response is dropped; neither rvalid_o is asserted.
  - protocol_err_o is set and stays set until reset.
- **Latency:** zero added cycles on both the request and the response path. The arbiter is purely muxing apart from the FIFO/FSM state.
- **Memory ordering:** the memory returns responses in grant order, no earlier than one cycle after the grant.

Test Plan:
- Fetch only:
  - Stimulus: instr_req_i=1, addr 0x80, mem_gnt_i=1 immediately; next cycle mem_rvalid_i=1, rdata 0x00000013.
  - Required: instr_gnt_o=1 in cycle 0; instr_rvalid_o=1 with rdata 0x00000013 in cycle 1; data_rvalid_o=0 throughout; outstanding_o goes 1→0.
- Tie after reset, DataFirst=1:
  - Stimulus: both requesters assert in the same cycle with mem_gnt_i=1.
  - Required: data granted first (mem_we_o follows data_we_i); instr granted the next cycle; a subsequent tie goes to data again.
- Lock:
  - Stimulus: data_req_i with addr 0x1000; mem_gnt_i low for 3 cycles; instr_req_i asserts in cycle 1.
  - Required: mem_addr_o stays 0x1000 until the grant; instr is granted only afterwards.
- Backpressure, MaxOutstanding=2:
  - Stimulus: two grants and no responses.
  - Required: mem_req_o=0 and outstanding_o=2. One mem_rvalid_i re-asserts mem_req_o the following cycle. Responses go to the issuing requesters in grant order.
- Spurious response:
  - Stimulus: mem_rvalid_i=1 with an empty FIFO.
  - Required: no rvalid_o on either side; protocol_err_o=1 and stays 1 until RST_N=0.
- Reset mid-operation:
  - Stimulus: one transaction outstanding, then RST_N low for one cycle.
  - Required: outstanding_o=0. A late rvalid sets protocol_err_o. A new fetch afterwards completes normally.
